// File: rtl/rf_debug_loader_pkg.sv
// Shared definitions for the register-file debug loader: widths, default
// command bytes, the frame-parser state encoding and a byte-lane helper.
package rf_debug_loader_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    localparam logic [7:0] DEF_CMD_WRITE = 8'h57;
    localparam logic [7:0] DEF_CMD_READ  = 8'h52;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WDATA,
        S_COMMIT,
        S_RADDR,
        S_RCAP,
        S_SEND
    } state_t;

    // Byte lane idx of a little-endian word (lane 0 = bits 7:0).
    function automatic logic [7:0] byte_sel(input logic [XLEN-1:0] word,
                                            input logic [1:0]      idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/rf_debug_loader.sv
// Byte-stream debug port for the register file. Parses write frames
// (CMD_WRITE, ADDR, D0..D3) into a single-cycle write-port pulse and read
// frames (CMD_READ, ADDR) into a four-byte little-endian response stream.
// Every output is a flop, so nothing on in_data reaches the rf_* ports
// combinationally.
module rf_debug_loader
    import rf_debug_loader_pkg::*;
#(
    parameter logic [7:0] CMD_WRITE = DEF_CMD_WRITE,
    parameter logic [7:0] CMD_READ  = DEF_CMD_READ,
    parameter bit         ALLOW_X0  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_raddr,
    input  logic [XLEN-1:0]       rf_rdata,
    output logic                  busy,
    output logic                  err
);

    state_t         state;
    state_t         state_d;
    logic           err_d;
    logic [1:0]     cnt;
    logic [XLEN-1:0] resp;

    logic in_fire;
    logic out_fire;
    logic write_allowed;

    assign in_fire       = in_valid && in_ready;
    assign out_fire      = out_valid && out_ready;
    // Register 0 writes are parsed as normal but only reach the port when enabled.
    assign write_allowed = ALLOW_X0 || (rf_waddr != '0);

    // Next-state decode of the frame parser.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state;
        err_d   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (in_fire) begin
                    if (in_data == CMD_WRITE)     state_d = S_WADDR;
                    else if (in_data == CMD_READ) state_d = S_RADDR;
                    else                          err_d   = 1'b1;
                end
            end
            S_WADDR:  if (in_fire) state_d = S_WDATA;
            S_WDATA:  if (in_fire && cnt == 2'd3) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            S_RADDR:  if (in_fire) state_d = S_RCAP;
            S_RCAP:   state_d = S_SEND;
            S_SEND:   if (out_fire && cnt == 2'd3) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register plus the handshake/status flops, all derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            rf_we     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            state     <= state_d;
            in_ready  <= (state_d == S_IDLE) || (state_d == S_WADDR) ||
                         (state_d == S_WDATA) || (state_d == S_RADDR);
            out_valid <= (state_d == S_SEND);
            busy      <= (state_d != S_IDLE);
            err       <= err_d;
            rf_we     <= (state_d == S_COMMIT) && write_allowed;
        end
    end

    // Datapath: address/data capture, read-response capture and byte serialisation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 2'd0;
            resp     <= '0;
            out_data <= 8'h00;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rf_raddr <= '0;
        end else begin
            unique case (state)
                S_WADDR: begin
                    if (in_fire) begin
                        rf_waddr <= in_data[REG_ADDR_W-1:0];
                        cnt      <= 2'd0;
                    end
                end
                S_WDATA: begin
                    if (in_fire) begin
                        rf_wdata[{cnt, 3'b000} +: 8] <= in_data;
                        cnt <= cnt + 2'd1;
                    end
                end
                S_RADDR: begin
                    if (in_fire) rf_raddr <= in_data[REG_ADDR_W-1:0];
                end
                S_RCAP: begin
                    resp     <= rf_rdata;
                    out_data <= byte_sel(rf_rdata, 2'd0);
                    cnt      <= 2'd0;
                end
                S_SEND: begin
                    // out_data only advances on acceptance, so it is stable through stalls.
                    if (out_fire && cnt != 2'd3) begin
                        cnt      <= cnt + 2'd1;
                        out_data <= byte_sel(resp, cnt + 2'd1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_debug_loader.sv
// Self-checking bench for rf_debug_loader. Two instances share the host
// stream: dut0 suppresses register-0 writes, dut1 allows them. A register
// file image answers reads; a monitor records every write pulse.
module tb_rf_debug_loader;
    import rf_debug_loader_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic [7:0] in_data;
    logic out_ready;

    logic        in_ready0, out_valid0, rf_we0, busy0, err0;
    logic [7:0]  out_data0;
    logic [4:0]  rf_waddr0, rf_raddr0;
    logic [31:0] rf_wdata0, rf_rdata0;

    logic        in_ready1, out_valid1, rf_we1, busy1, err1;
    logic [7:0]  out_data1;
    logic [4:0]  rf_waddr1, rf_raddr1;
    logic [31:0] rf_wdata1, rf_rdata1;

    logic [31:0] mem [32];
    logic [36:0] wq0 [$];
    logic [36:0] wq1 [$];

    int checks = 0;
    int errors = 0;

    assign rf_rdata0 = mem[rf_raddr0];
    assign rf_rdata1 = mem[rf_raddr1];

    rf_debug_loader #(.ALLOW_X0(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .rf_waddr(rf_waddr0), .rf_wdata(rf_wdata0), .rf_we(rf_we0),
        .rf_raddr(rf_raddr0), .rf_rdata(rf_rdata0),
        .busy(busy0), .err(err0)
    );

    rf_debug_loader #(.ALLOW_X0(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1), .rf_we(rf_we1),
        .rf_raddr(rf_raddr1), .rf_rdata(rf_rdata1),
        .busy(busy1), .err(err1)
    );

    always #5 clk = ~clk;

    // Record every cycle in which a write pulse is present.
    always @(negedge clk) begin
        if (rf_we0 === 1'b1) wq0.push_back({rf_waddr0, rf_wdata0});
        if (rf_we1 === 1'b1) wq1.push_back({rf_waddr1, rf_wdata1});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte after gap idle cycles; returns at the negedge after the transfer.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready0 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("in_ready_timeout", {36'd0, in_ready0}, 37'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Full write frame; expected effect derived from address/data and the X0 rule.
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input int gap);
        logic [4:0] a;
        logic       allow0;
        a      = addr[4:0];
        allow0 = (a != 5'd0);
        wq0.delete();
        wq1.delete();
        send_byte(DEF_CMD_WRITE, 0);
        send_byte(addr, gap);
        for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], gap);
        check("we_after_d3_0", {36'd0, rf_we0}, {36'd0, allow0});
        check("we_after_d3_1", {36'd0, rf_we1}, 37'd1);
        check("waddr1", {32'd0, rf_waddr1}, {32'd0, a});
        check("wdata1", {5'd0, rf_wdata1}, {5'd0, data});
        check("in_ready_commit", {36'd0, in_ready0}, 37'd0);
        check("busy_commit", {36'd0, busy0}, 37'd1);
        @(negedge clk);
        check("we_cleared", {35'd0, rf_we0, rf_we1}, 37'd0);
        check("busy_fall", {35'd0, busy0, busy1}, 37'd0);
        check("in_ready_idle", {36'd0, in_ready0}, 37'd1);
        @(negedge clk);
        #1;
        check("wq0_count", 37'(wq0.size()), allow0 ? 37'd1 : 37'd0);
        check("wq1_count", 37'(wq1.size()), 37'd1);
        if (allow0 && wq0.size() > 0) check("wq0_entry", wq0[0], {a, data});
        if (wq1.size() > 0) check("wq1_entry", wq1[0], {a, data});
    endtask

    // Read frame; optionally withhold out_ready for stall_n cycles on byte stall_idx.
    task automatic do_read(input logic [7:0] addr, input int stall_idx, input int stall_n);
        logic [31:0] exp;
        logic [7:0]  eb;
        int          n;
        exp = mem[addr[4:0]];
        out_ready = 1'b0;
        send_byte(DEF_CMD_READ, 0);
        send_byte(addr, 0);
        check("out_valid_rcap", {36'd0, out_valid0}, 37'd0);
        @(negedge clk);
        check("out_valid_latency", {36'd0, out_valid0}, 37'd1);
        for (int i = 0; i < 4; i++) begin
            eb = exp[8*i +: 8];
            n = 0;
            while (out_valid0 !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) check("out_valid_timeout", {36'd0, out_valid0}, 37'd1);
            check($sformatf("rbyte%0d_0", i), {29'd0, out_data0}, {29'd0, eb});
            check($sformatf("rbyte%0d_1", i), {29'd0, out_data1}, {29'd0, eb});
            if (i == stall_idx) begin
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    check("stall_hold", {28'd0, out_valid0, out_data0}, {28'd0, 1'b1, eb});
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check("read_done", {34'd0, out_valid0, busy0, in_ready0}, {34'd0, 3'b001});
    endtask

    initial begin
        logic [7:0]  ab;
        logic [31:0] d;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[9] = 32'hDEADBEEF;

        #1;
        check("rst_in_ready", {36'd0, in_ready0}, 37'd1);
        check("rst_out_valid", {36'd0, out_valid0}, 37'd0);
        check("rst_out_data", {29'd0, out_data0}, 37'd0);
        check("rst_rf_we", {35'd0, rf_we0, rf_we1}, 37'd0);
        check("rst_waddr", {32'd0, rf_waddr0}, 37'd0);
        check("rst_wdata", {5'd0, rf_wdata0}, 37'd0);
        check("rst_raddr", {32'd0, rf_raddr0}, 37'd0);
        check("rst_busy", {36'd0, busy0}, 37'd0);
        check("rst_err", {36'd0, err0}, 37'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic write and read with a stall on the second response byte.
        do_write(8'h05, 32'h12345678, 0);
        do_read(8'h09, 1, 4);

        // Register 0: suppressed in dut0, issued in dut1.
        do_write(8'h00, 32'h44332211, 0);

        // Unknown command byte.
        send_byte(8'h41, 0);
        check("err_pulse", {36'd0, err0}, 37'd1);
        check("err_busy", {36'd0, busy0}, 37'd0);
        @(negedge clk);
        check("err_cleared", {36'd0, err0}, 37'd0);
        do_read(8'h01, 4, 0);

        // Reset after D1: nothing may be written.
        wq0.delete();
        wq1.delete();
        send_byte(DEF_CMD_WRITE, 0);
        send_byte(8'h0A, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", {35'd0, busy0, busy1}, 37'd0);
        check("midrst_in_ready", {36'd0, in_ready0}, 37'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_no_write", 37'(wq0.size() + wq1.size()), 37'd0);

        // Reset while the write pulse is high clears it at once.
        send_byte(DEF_CMD_WRITE, 0);
        send_byte(8'h06, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h5A, 0);
        #2 rst = 1'b1;
        #1;
        check("commit_rst_we", {35'd0, rf_we0, rf_we1}, 37'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_write(8'h03, 32'hCAFEF00D, 0);

        // Upper address bits ignored; gaps between bytes.
        do_write(8'hE7, 32'h0BADC0DE, 0);
        do_write(8'hE7, 32'h0BADC0DE, 3);

        // Randomised frames.
        for (int k = 0; k < 24; k++) begin
            ab = 8'($urandom);
            d  = $urandom;
            if ($urandom_range(0, 1) == 0)
                do_write(ab, d, int'($urandom_range(0, 2)));
            else
                do_read(ab, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_debug_loader.md
Name: rf_debug_loader

Overview:
- Byte-stream debug port that writes into and reads from the core's register file, replacing hex-file preload with a runtime load/dump path.
- Parses command frames from an 8-bit valid/ready input stream.
- Drives the register file write port (address/data/write-enable) and its read port.
- Returns read data as bytes on an 8-bit valid/ready output stream. Sits between a host link (UART/JTAG bridge) and the register file.

Parameters:
- CMD_WRITE, 8'h57, command byte opening a write frame.
- CMD_READ, 8'h52, command byte opening a read frame.
- ALLOW_X0, 0, when 1 a write to register 0 is issued; when 0 it is parsed but suppressed.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  host byte valid.
- in_ready  out  1  loader accepts byte.
- in_data  in  8  host byte.
- out_valid  out  1  response byte valid.
- out_ready  in  1  host accepts response byte.
- out_data  out  8  response byte.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  32  register file write data.
- rf_we  out  1  register file write enable, single-cycle pulse.
- rf_raddr  out  5  register file read address.
- rf_rdata  in  32  register file read data, combinational from rf_raddr.
- busy  out  1  frame in progress; core is held while high.
- err  out  1  one-cycle pulse on unknown command byte.

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE.
  - in_ready=1, out_valid=0, out_data=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, rf_raddr=0.
  - busy=0, err=0, byte counter=0.
- Byte transfer: occurs when valid&&ready at the clock edge. Producers hold data stable while valid && !ready.
- Frame formats:
  - Write: CMD_WRITE, ADDR, D0, D1, D2, D3. Data little-endian: D0 is bits 7:0.
  - Read: CMD_READ, ADDR. Response is R0..R3, little-endian.
  - ADDR bits 4:0 select the register; bits 7:5 are ignored.
- States:
  - IDLE: in_ready=1.
    - CMD_WRITE -> WADDR.
    - CMD_READ -> RADDR.
    - Other byte -> err=1 next cycle, stay IDLE.
  - WADDR: in_ready=1. Byte captured into rf_waddr -> WDATA, counter=0.
  - WDATA: in_ready=1. Byte shifted into rf_wdata[8*cnt +: 8]. On cnt==3 -> COMMIT.
  - COMMIT: in_ready=0. rf_we=1 for exactly this one cycle, unless rf_waddr==0 && ALLOW_X0==0. Then -> IDLE.
  - RADDR: in_ready=1. Byte captured into rf_raddr -> RCAP.
  - RCAP: in_ready=0. rf_rdata captured into a 32-bit response register at the end of the cycle -> SEND, counter=0.
  - SEND: in_ready=0, out_valid=1, out_data = resp[8*cnt +: 8].
    - On out_ready: cnt++.
    - After cnt==3 is accepted -> IDLE, out_valid=0.
- Latency:
  - rf_we is high in the cycle after D3 is accepted.
  - First out_valid comes 2 cycles after the ADDR byte is accepted.
  - IDLE accepts the next command in the cycle after COMMIT, or after the last response byte.
- busy=1 in every state except IDLE. It is registered, so it rises the cycle after the command byte is accepted.
- in_valid low mid-frame: wait indefinitely, no timeout. out_ready low: hold out_data/out_valid stable.
- rf_waddr, rf_wdata and rf_raddr hold their last values in IDLE.
- Reset mid-frame: frame discarded, partial data is never written, any in-flight rf_we pulse is cleared immediately.
- Outputs are all registered; no combinational path from in_data to the rf_* ports.

Decomposition:
- Shared package holds:
  - state enum (IDLE, WADDR, WDATA, COMMIT, RADDR, RCAP, SEND);
  - default command byte constants;
  - REG_ADDR_W=5 and XLEN=32.
- No sub-module required. The byte-serialiser for SEND may optionally be split out as rf_byte_serializer (32-bit in, 8-bit valid/ready out).

Test Plan:
- Frame 57,05,78,56,34,12 with continuous in_valid -> one cycle with rf_we=1, rf_waddr=5, rf_wdata=32'h12345678; busy falls the next cycle.
- Frame 52,09 with rf_rdata model returning 32'hDEADBEEF for address 9 -> out bytes EF,BE,AD,DE. Insert out_ready stalls on the 2nd byte; out_data must hold BE throughout the stall.
- Write to register 0 (57,00,11,22,33,44) with ALLOW_X0=0 -> rf_we never asserts and state returns to IDLE. With ALLOW_X0=1 -> rf_we=1, rf_wdata=32'h44332211.
- Byte 0x41 in IDLE -> err=1 for exactly one cycle, busy stays 0; a following 52,01 frame still works.
- Assert rst asynchronously after D1 of a write frame -> rf_we stays 0, busy=0 immediately. Then send a full write to register 3 -> only that write occurs.
- ADDR byte 0xE7 on a write -> rf_waddr=7. in_valid gaps of 3 cycles between data bytes -> same result, with rf_we pulse width still 1.
